// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - two-stage mantissa normalizer: leading-one search, left shift, clamped exponent decrement
// Stage 1 captures the operand; stage 2 captures the normalized result that drives the outputs.
module fp_norm_pipe #(
  parameter int XLEN = 64,
  parameter int XLOG = 6,
  parameter int ELEN = 13
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] mant_in,
  input  logic [ELEN-1:0] exp_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mant_out,
  output logic [ELEN-1:0] exp_out,
  output logic [XLOG-1:0] shift_out,
  output logic            zero_out
);

  localparam logic [31:0] XLEN_U = 32'(XLEN);

  logic            r_s1_valid;
  logic [XLEN-1:0] r_s1_mant;
  logic [ELEN-1:0] r_s1_exp;

  logic            r_s2_valid;
  logic [XLEN-1:0] r_s2_mant;
  logic [ELEN-1:0] r_s2_exp;
  logic [XLOG-1:0] r_s2_shift;
  logic            r_s2_zero;

  logic            w_adv1;
  logic            w_adv2;
  logic            w_accept;
  logic [XLOG-1:0] w_lz_idx;
  logic            w_lz_v;
  logic [XLOG-1:0] w_clz;
  logic [XLOG-1:0] w_shift;
  logic [XLEN-1:0] w_mant_sh;
  logic [ELEN-1:0] w_exp_adj;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1 && !flush;
  assign w_accept = in_valid && in_ready;

  // Ascending scan: the highest set bit is the last one written, giving the leading-one index.
  always_comb begin
    w_lz_idx = '0;
    w_lz_v   = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (r_s1_mant[i]) begin
        w_lz_idx = XLOG'(i);
        w_lz_v   = 1'b1;
      end
    end
  end

  assign w_clz = ~w_lz_idx;

  // Shift is min(clz, exp) so an exponent too small to absorb the full shift leaves a subnormal.
  always_comb begin
    w_shift = w_clz;
    if (32'(r_s1_exp) < XLEN_U) begin
      if (r_s1_exp[XLOG-1:0] < w_clz) begin
        w_shift = r_s1_exp[XLOG-1:0];
      end
    end
    if (!w_lz_v) begin
      w_shift = '0;
    end
  end

  assign w_mant_sh = r_s1_mant << w_shift;
  assign w_exp_adj = w_lz_v ? (r_s1_exp - ELEN'(w_shift)) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_exp   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mant  <= '0;
      r_s2_exp   <= '0;
      r_s2_shift <= '0;
      r_s2_zero  <= 1'b0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        if (w_adv1) begin
          r_s1_valid <= in_valid;
        end
        if (w_adv2) begin
          r_s2_valid <= r_s1_valid;
        end
      end
      if (w_accept) begin
        r_s1_mant <= mant_in;
        r_s1_exp  <= exp_in;
      end
      if (w_adv2 && r_s1_valid) begin
        r_s2_mant  <= w_lz_v ? w_mant_sh : '0;
        r_s2_exp   <= w_exp_adj;
        r_s2_shift <= w_shift;
        r_s2_zero  <= !w_lz_v;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign mant_out  = r_s2_mant;
  assign exp_out   = r_s2_exp;
  assign shift_out = r_s2_shift;
  assign zero_out  = r_s2_zero;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - directed-vector bench for fp_norm_pipe
// Inputs change on the falling edge; outputs are sampled on the falling edge or shortly after.
module tb_fp_norm_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] mant_in;
  logic [12:0] exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] mant_out;
  logic [12:0] exp_out;
  logic [5:0]  shift_out;
  logic        zero_out;

  int n_vec = 0;
  int n_err = 0;

  fp_norm_pipe #(.XLEN(64), .XLOG(6), .ELEN(13)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .shift_out (shift_out),
    .zero_out  (zero_out)
  );

  always #5 clock = ~clock;

  task automatic issue(input logic [63:0] m, input logic [12:0] e);
    @(negedge clock);
    in_valid  = 1'b1;
    mant_in   = m;
    exp_in    = e;
    out_ready = 1'b1;
    @(negedge clock);
    in_valid  = 1'b0;
    mant_in   = '0;
    exp_in    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mant_in = '0; exp_in = '0;
    #2;
    n_vec++;
    if ({out_valid, mant_out, exp_out, shift_out, zero_out} !== 85'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, mant_out, exp_out, shift_out, zero_out});
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_normalize();
    logic [63:0] vm [0:2];
    logic [12:0] ve [0:2];
    logic [83:0] vx [0:2];
    vm = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_00F0};
    ve = '{13'd100, 13'd100, 13'd1000};
    vx = '{{64'h8000_0000_0000_0000, 13'd100, 6'd0,  1'b0},
           {64'h8000_0000_0000_0000, 13'd37,  6'd63, 1'b0},
           {64'hF000_0000_0000_0000, 13'd944, 6'd56, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      issue(vm[i], ve[i]);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL normalize_early[%0d]: got out_valid=%b want 0", i, out_valid);
      end
      @(negedge clock);
      n_vec++;
      if ({out_valid, mant_out, exp_out, shift_out, zero_out} !== {1'b1, vx[i]}) begin
        n_err++;
        $display("FAIL normalize[%0d]: got %h want %h", i,
                 {out_valid, mant_out, exp_out, shift_out, zero_out}, {1'b1, vx[i]});
      end
    end
  endtask

  task automatic test_clamp();
    logic [63:0] vm [0:4];
    logic [12:0] ve [0:4];
    logic [83:0] vx [0:4];
    vm = '{64'h0000_0001_0000_0000, 64'h1, 64'h1, 64'h0000_0000_0000_00F0, 64'h0000_0000_0001_0000};
    ve = '{13'd10, 13'd63, 13'd62, 13'd0, 13'd64};
    vx = '{{64'h0000_0400_0000_0000, 13'd0,  6'd10, 1'b0},
           {64'h8000_0000_0000_0000, 13'd0,  6'd63, 1'b0},
           {64'h4000_0000_0000_0000, 13'd0,  6'd62, 1'b0},
           {64'h0000_0000_0000_00F0, 13'd0,  6'd0,  1'b0},
           {64'h8000_0000_0000_0000, 13'd17, 6'd47, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      issue(vm[i], ve[i]);
      @(negedge clock);
      n_vec++;
      if ({out_valid, mant_out, exp_out, shift_out, zero_out} !== {1'b1, vx[i]}) begin
        n_err++;
        $display("FAIL clamp[%0d]: got %h want %h", i,
                 {out_valid, mant_out, exp_out, shift_out, zero_out}, {1'b1, vx[i]});
      end
    end
  endtask

  task automatic test_zero();
    logic [12:0] ve [0:1];
    ve = '{13'd55, 13'h1FFF};
    for (int i = 0; i < 2; i++) begin
      issue(64'h0, ve[i]);
      @(negedge clock);
      n_vec++;
      if ({out_valid, mant_out, exp_out, shift_out, zero_out} !== {1'b1, 64'h0, 13'd0, 6'd0, 1'b1}) begin
        n_err++;
        $display("FAIL zero[%0d]: got %h want %h", i,
                 {out_valid, mant_out, exp_out, shift_out, zero_out}, {1'b1, 64'h0, 13'd0, 6'd0, 1'b1});
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int got = 0;
    int c = 0;
    int extra = 0;
    while (got < 8 && c < 60) begin
      @(negedge clock);
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (k < 8);
      mant_in   = 64'd1 << k;
      exp_in    = 13'd200;
      #1;
      if (c == 2 || c == 3) begin
        n_vec++;
        if (in_ready !== (c == 2)) begin
          n_err++;
          $display("FAIL bp_in_ready[c=%0d]: got %b want %b", c, in_ready, (c == 2));
        end
      end
      if (c >= 3 && c <= 6) begin
        n_vec++;
        if ({out_valid, exp_out} !== {1'b1, 13'(137 + got)}) begin
          n_err++;
          $display("FAIL bp_hold[c=%0d]: got %h want %h", c, {out_valid, exp_out}, {1'b1, 13'(137 + got)});
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if ({mant_out, exp_out, shift_out, zero_out} !==
            {64'h8000_0000_0000_0000, 13'(137 + got), 6'(63 - got), 1'b0}) begin
          n_err++;
          $display("FAIL bp_result[%0d]: got %h want %h", got, {mant_out, exp_out, shift_out, zero_out},
                   {64'h8000_0000_0000_0000, 13'(137 + got), 6'(63 - got), 1'b0});
        end
        got++;
      end
      if (in_valid && in_ready) k++;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (out_valid) extra++;
    end
    n_vec++;
    if ({got, extra} !== {32'd8, 32'd0}) begin
      n_err++;
      $display("FAIL bp_count: got results=%0d extra=%0d want 8 and 0", got, extra);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    @(negedge clock);
    out_ready = 1'b1; in_valid = 1'b1; mant_in = 64'h1; exp_in = 13'd100;
    @(negedge clock);
    mant_in = 64'h2;
    @(negedge clock);
    mant_in = 64'h4;
    flush = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_cycle: got in_ready,out_valid=%b want 01", {in_ready, out_valid});
    end
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_next: got out_valid=%b want 0", out_valid);
    end
    repeat (3) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL flush_drop: got %0d late results want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    issue(64'h1, 13'd100);
    @(negedge clock);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: got out_valid=%b want 1", out_valid);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, mant_out, exp_out, shift_out, zero_out} !== 85'd0) begin
      n_err++;
      $display("FAIL rst_mid_async: got %h want 0", {out_valid, mant_out, exp_out, shift_out, zero_out});
    end
    @(negedge clock);
    reset = 1'b0;
    issue(64'h0000_0000_8000_0000, 13'd40);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_early: got out_valid=%b want 0", out_valid);
    end
    @(negedge clock);
    n_vec++;
    if ({out_valid, mant_out, exp_out, shift_out, zero_out} !==
        {1'b1, 64'h8000_0000_0000_0000, 13'd8, 6'd32, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid_after: got %h want %h", {out_valid, mant_out, exp_out, shift_out, zero_out},
               {1'b1, 64'h8000_0000_0000_0000, 13'd8, 6'd32, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_normalize();
    test_clamp();
    test_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Two-stage pipelined normalization unit sitting directly downstream of the leading-zero counters (lzc_4 … lzc_256) in the FPU datapath.
- Takes an unnormalized mantissa and a biased exponent from add/sub/fma/conversion results.
- Finds the leading one, left-shifts the mantissa to bring it to the MSB, and decrements the exponent.
- Clamps at exponent 0 so that results which would underflow remain subnormal.
- Uses a valid/ready handshake with full throughput and backpressure.

Parameters:
- XLEN, 64, mantissa width; power of two, 4..256 (selects lzc_XLEN instance).
- XLOG, 6, log2(XLEN); width of shift/count fields.
- ELEN, 13, biased exponent width, unsigned.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  input operand valid
- in_ready  out  1  unit can accept this cycle
- mant_in  in  XLEN  unnormalized mantissa
- exp_in  in  ELEN  biased exponent, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- mant_out  out  XLEN  normalized mantissa
- exp_out  out  ELEN  adjusted exponent
- shift_out  out  XLOG  applied left-shift amount
- zero_out  out  1  mant_in was all zeros

Behaviour:
- Reset (asynchronous, active-high): s1_valid=0, s2_valid=0. All stage data registers are 0, so out_valid=0, mant_out=0, exp_out=0, shift_out=0, zero_out=0.
- Pipeline:
  - S1 registers mant_in/exp_in and the lzc result.
  - S2 registers the shifted mantissa, exponent, shift and zero flag. The outputs are the S2 registers.
- Latency and throughput: latency is exactly 2 cycles from the accept edge to out_valid with no stall. Throughput is 1 result per cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 && !flush. in_ready is combinational, with no dependency on in_valid.
  - Stalled stages hold their data bit-exact. Results leave in order with no loss and no duplication.
- Leading-zero count:
  - Use lzc_XLEN on the S1-registered mantissa. Its c output is the index of the leading one, so clz = ~c (XLOG bits), and v=1 iff the mantissa is nonzero.
  - An equivalent in-block priority encoder is permitted only if bit-identical.
- Arithmetic, performed in S1→S2:
  - shift = (clz < exp) ? clz : exp[XLOG-1:0] when exp < XLEN, otherwise clz. This equals min(clz, exp).
  - mant_out = mant << shift, zero-filled from the LSB.
  - exp_out = exp − shift, which never goes negative.
  - shift_out = shift.
- Zero mantissa (v=0): zero_out=1, mant_out=0, exp_out=0, shift_out=0. exp_in is ignored.
- exp_in=0 and nonzero mantissa: shift=0, output passes through unchanged, zero_out=0.
- Already normalized (MSB set): shift=0, exp unchanged.
- Flush:
  - On the next edge, s1_valid=0 and s2_valid=0. Data registers may retain stale values.
  - An in_valid in the same cycle is not accepted, because in_ready=0.
  - Flush overrides out_ready: a result presented in the flush cycle counts as transferred only if out_ready=1 in that cycle.
- Reset asserted mid-operation: all in-flight ops are dropped immediately (asynchronous). Outputs return to their reset values before the next edge.

Test Plan (XLEN=64, ELEN=13):
- Normalized passthrough: mant_in=0x8000_0000_0000_0000, exp_in=100 → 2 cycles later mant_out unchanged, exp_out=100, shift_out=0, zero_out=0.
- Full shift: mant_in=0x0000_0000_0000_0001, exp_in=100 → mant_out=0x8000_0000_0000_0000, exp_out=37, shift_out=63.
- Underflow clamp: mant_in=0x0000_0001_0000_0000 (clz=31), exp_in=10 → shift_out=10, mant_out=0x0000_0400_0000_0000, exp_out=0.
- Zero operand: mant_in=0, exp_in=55 → zero_out=1, mant_out=0, exp_out=0, shift_out=0.
- Backpressure: stream 1<<k for k=0..7 (exp=200) back-to-back while out_ready=0 for cycles 3..6 → in_ready falls after 2 unconsumed ops are held. All 8 results arrive in order with shift_out=63−k and exp_out=137+k, with no duplicates.
- Flush and reset: with 2 ops in flight, pulse flush together with in_valid → next cycle out_valid=0, third op not accepted. Separately, assert reset mid-stream → out_valid drops before the next edge. After release, the first new op emerges 2 cycles after accept.
